iter_divider: RTL and testbench

- Multicycle 32-bit integer divider for the processor's execute stage.
- Complements the single-cycle ALU adder path: multiplication-class inverse by repeated trial subtraction, one quotient bit per clock (restoring, MSB first).
- Accepts a one-cycle start pulse and returns quotient, remainder and divide-by-zero flag with a one-cycle ready pulse.
- The pipeline stalls on `busy`.

---
 rtl/iter_divider.sv | 213 +++++++++++++++++++++
 tb/tb_iter_divider.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multicycle restoring integer divider, one quotient bit per clock
//
// Purpose:
//   Divides dataA by dataB with a restoring algorithm that produces the quotient
//   MSB first. A normal divide takes 33 cycles from acceptance to data_resultRDY:
//   32 iterations followed by one FIX cycle. A zero divisor completes one cycle
//   after acceptance with data_exception set and busy never raised.
//
// Configuration macro:
//   DIV_SIGNED_EN - when defined, operands are two's-complement signed. The
//                   quotient truncates toward zero and the remainder takes the
//                   dividend's sign. When undefined, everything is unsigned.
//
// Ports:
//   clock          in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   ctrl_div       in   start strobe, sampled only while idle
//   dataA          in   dividend, captured on an accepted start
//   dataB          in   divisor, captured on an accepted start
//   quotient       out  registered quotient, held until the next completion
//   remainder      out  registered remainder, held until the next completion
//   data_resultRDY out  one-cycle completion pulse
//   data_exception out  divide-by-zero flag, held until the next completion
//   busy           out  high while a divide is in flight

module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             data_resultRDY,
  output logic             data_exception,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Working registers: r_q is the partial remainder, q_q starts as the dividend
  // magnitude and is shifted left while quotient bits enter at the bottom.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Set on acceptance of a zero divisor; r_q then holds the raw dividend that
  // becomes the remainder on the following edge.
  logic             dz_pend_q, dz_pend_d;

  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             rdy_q, rdy_d;
  logic             exc_q, exc_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

`ifdef DIV_SIGNED_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;

  // Unary minus of the most negative value wraps to itself, which is exactly
  // the unsigned magnitude the iteration needs.
  assign a_mag    = dataA[WIDTH-1] ? (-dataA) : dataA;
  assign b_mag    = dataB[WIDTH-1] ? (-dataB) : dataB;
  assign quot_fix = neg_quot_q ? (-q_q) : q_q;
  assign rem_fix  = neg_rem_q  ? (-r_q) : r_q;
`else
  assign a_mag    = dataA;
  assign b_mag    = dataB;
  assign quot_fix = q_q;
  assign rem_fix  = r_q;
`endif

  // One restoring step. The shifted remainder needs WIDTH+1 bits; when the
  // trial subtraction succeeds the result is below the divisor, so the low
  // WIDTH bits of the wrapped difference are exact.
  logic [WIDTH:0]   r_shift;
  logic             trial_ok;
  logic [WIDTH-1:0] trial;

  assign r_shift  = {r_q, q_q[WIDTH-1]};
  assign trial_ok = (r_shift >= {1'b0, b_q});
  assign trial    = r_shift[WIDTH-1:0] - b_q;

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    q_d       = q_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    dz_pend_d = 1'b0;
    quot_d    = quot_q;
    rem_d     = rem_q;
    rdy_d     = 1'b0;
    exc_d     = exc_q;
`ifdef DIV_SIGNED_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
`endif

    case (state_q)
      IDLE: begin
        // A pending zero-divisor completion retires here; reading r_q keeps it
        // independent of a new start accepted on the same edge.
        if (dz_pend_q) begin
          quot_d = '0;
          rem_d  = r_q;
          exc_d  = 1'b1;
          rdy_d  = 1'b1;
        end

        if (ctrl_div) begin
          b_d   = b_mag;
          q_d   = a_mag;
          cnt_d = CW'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
          neg_quot_d = dataA[WIDTH-1] ^ dataB[WIDTH-1];
          neg_rem_d  = dataA[WIDTH-1];
`endif
          if (dataB == '0) begin
            dz_pend_d = 1'b1;
            r_d       = dataA;
          end else begin
            r_d     = '0;
            state_d = ITER;
          end
        end
      end

      ITER: begin
        if (trial_ok) begin
          r_d = trial;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = r_shift[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end

      FIX: begin
        quot_d  = quot_fix;
        rem_d   = rem_fix;
        exc_d   = 1'b0;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      r_q       <= '0;
      q_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      dz_pend_q <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      rdy_q     <= 1'b0;
      exc_q     <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      q_q       <= q_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      dz_pend_q <= dz_pend_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      rdy_q     <= rdy_d;
      exc_q     <= exc_d;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign quotient       = quot_q;
  assign remainder      = rem_q;
  assign data_resultRDY = rdy_q;
  assign data_exception = exc_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - randomized self-checking bench for iter_divider

module tb_iter_divider;

  logic        clock;
  logic        reset_n;
  logic        ctrl_div;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        data_resultRDY;
  logic        data_exception;
  logic        busy;

  int n_tests;
  int n_fail;

  iter_divider #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_div       (ctrl_div),
    .dataA          (dataA),
    .dataB          (dataB),
    .quotient       (quotient),
    .remainder      (remainder),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: plain 64-bit integer division, which truncates toward zero and
  // gives the remainder the dividend's sign; the result is cut to 32 bits.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic e);
    longint ad;
    longint bd;
    longint qd;
    longint rd;
    if (b == 32'd0) begin
      q = 32'd0;
      r = a;
      e = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      ad = longint'(signed'(a));
      bd = longint'(signed'(b));
`else
      ad = longint'({32'd0, a});
      bd = longint'({32'd0, b});
`endif
      qd = ad / bd;
      rd = ad % bd;
      q  = qd[31:0];
      r  = rd[31:0];
      e  = 1'b0;
    end
  endfunction

  // Issues one op from the current (post-edge) time and returns once the ready
  // pulse is sampled, leaving the caller inside the ready cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int poke_at,
                        output int lat, output logic first_busy, output logic [31:0] first_q,
                        output logic busy_seen, output logic [31:0] q, output logic [31:0] r,
                        output logic e);
    ctrl_div = 1'b1;
    dataA    = a;
    dataB    = b;
    @(posedge clock); #1;
    ctrl_div   = 1'b0;
    dataA      = $urandom;
    dataB      = $urandom;
    lat        = 0;
    first_busy = busy;
    first_q    = quotient;
    busy_seen  = busy;
    while (!data_resultRDY && lat < 100) begin
      if (poke_at != 0 && lat == poke_at) begin
        ctrl_div = 1'b1;
        dataA    = $urandom;
        dataB    = $urandom;
      end
      @(posedge clock); #1;
      ctrl_div = 1'b0;
      lat++;
      if (!data_resultRDY) busy_seen = busy_seen | busy;
    end
    q = quotient;
    r = remainder;
    e = data_exception;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    ctrl_div = 1'b0;
    dataA    = 32'd0;
    dataB    = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    n_tests++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL reset_quotient got %h want 0", quotient); end
    n_tests++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL reset_remainder got %h want 0", remainder); end
    n_tests++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", data_resultRDY); end
    n_tests++; if (data_exception !== 1'b0) begin n_fail++; $display("FAIL reset_exception got %b want 0", data_exception); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    logic [31:0] a_tab [$];
    logic [31:0] b_tab [$];
    logic [31:0] q, r, fq, eq, er;
    logic        e, fb, bs, ee;
    int          lat;
    a_tab = '{32'd100, 32'd7, 32'd0, 32'hFFFFFFFF};
    b_tab = '{32'd7, 32'd100, 32'd5, 32'd1};
`ifdef DIV_SIGNED_EN
    a_tab.push_back(32'hFFFFFF9C); b_tab.push_back(32'd7);
    a_tab.push_back(32'd100);      b_tab.push_back(32'hFFFFFFF9);
    a_tab.push_back(32'h80000000); b_tab.push_back(32'hFFFFFFFF);
    a_tab.push_back(32'h80000000); b_tab.push_back(32'h80000000);
`else
    a_tab.push_back(32'hFFFFFFFF); b_tab.push_back(32'd2);
    a_tab.push_back(32'h80000000); b_tab.push_back(32'hFFFFFFFF);
    a_tab.push_back(32'hFFFFFFFE); b_tab.push_back(32'hFFFFFFFF);
`endif
    foreach (a_tab[i]) begin
      model(a_tab[i], b_tab[i], eq, er, ee);
      run_op(a_tab[i], b_tab[i], 0, lat, fb, fq, bs, q, r, e);
      n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL dir_latency %h/%h got %0d want 33", a_tab[i], b_tab[i], lat); end
      n_tests++; if (fb !== 1'b1) begin n_fail++; $display("FAIL dir_busy %h/%h got %b want 1", a_tab[i], b_tab[i], fb); end
      n_tests++; if (q !== eq) begin n_fail++; $display("FAIL dir_quotient %h/%h got %h want %h", a_tab[i], b_tab[i], q, eq); end
      n_tests++; if (r !== er) begin n_fail++; $display("FAIL dir_remainder %h/%h got %h want %h", a_tab[i], b_tab[i], r, er); end
      n_tests++; if (e !== ee) begin n_fail++; $display("FAIL dir_exception %h/%h got %b want %b", a_tab[i], b_tab[i], e, ee); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dir_busy_at_ready got %b want 0", busy); end
      @(posedge clock); #1;
      n_tests++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL dir_ready_width got %b want 0", data_resultRDY); end
      n_tests++; if (quotient !== eq) begin n_fail++; $display("FAIL dir_quotient_hold got %h want %h", quotient, eq); end
    end
    model(32'd100, 32'd7, eq, er, ee);
    n_tests++; if (eq !== 32'd14 || er !== 32'd2) begin n_fail++; $display("FAIL model_100_7 got %h %h want e 2", eq, er); end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r, fq;
    logic        e, fb, bs;
    int          lat;
    run_op(32'h12345678, 32'd0, 0, lat, fb, fq, bs, q, r, e);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL dz_latency got %0d want 1", lat); end
    n_tests++; if (bs !== 1'b0) begin n_fail++; $display("FAIL dz_busy got %b want 0", bs); end
    n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL dz_exception got %b want 1", e); end
    n_tests++; if (q !== 32'd0) begin n_fail++; $display("FAIL dz_quotient got %h want 0", q); end
    n_tests++; if (r !== 32'h12345678) begin n_fail++; $display("FAIL dz_remainder got %h want 12345678", r); end
    @(posedge clock); #1;
    n_tests++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL dz_ready_width got %b want 0", data_resultRDY); end
    n_tests++; if (data_exception !== 1'b1) begin n_fail++; $display("FAIL dz_exception_hold got %b want 1", data_exception); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, fq, eq, er;
    logic        e, fb, bs, ee;
    int          lat, poke, exp_lat;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = $urandom;
        3: b = $urandom >> $urandom_range(0, 31);
        default: b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h80000000;
      endcase
      case ($urandom_range(0, 2))
        0: a = $urandom;
        1: a = $urandom >> $urandom_range(0, 31);
        default: a = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
      endcase
      poke    = (b != 32'd0 && (i % 3) == 0) ? $urandom_range(1, 31) : 0;
      exp_lat = (b == 32'd0) ? 1 : 33;
      model(a, b, eq, er, ee);
      run_op(a, b, poke, lat, fb, fq, bs, q, r, e);
      n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd_latency %h/%h got %0d want %0d", a, b, lat, exp_lat); end
      n_tests++; if (bs !== (b != 32'd0)) begin n_fail++; $display("FAIL rnd_busy %h/%h got %b want %b", a, b, bs, (b != 32'd0)); end
      n_tests++; if (q !== eq) begin n_fail++; $display("FAIL rnd_quotient %h/%h got %h want %h", a, b, q, eq); end
      n_tests++; if (r !== er) begin n_fail++; $display("FAIL rnd_remainder %h/%h got %h want %h", a, b, r, er); end
      n_tests++; if (e !== ee) begin n_fail++; $display("FAIL rnd_exception %h/%h got %b want %b", a, b, e, ee); end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] q, r, fq;
    logic        e, fb, bs;
    int          lat, stray;
    run_op(32'd100, 32'd7, 0, lat, fb, fq, bs, q, r, e);
    n_tests++; if (q !== 32'd14) begin n_fail++; $display("FAIL pre_reset_quotient got %h want e", q); end
    @(posedge clock); #1;
    ctrl_div = 1'b1; dataA = 32'd100; dataB = 32'd7;
    @(posedge clock); #1;
    ctrl_div = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    ctrl_div = 1'b1; dataA = 32'd9; dataB = 32'd3;
    @(posedge clock); #1;
    ctrl_div = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy got %b want 1", busy); end
    repeat (4) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    #1;
    n_tests++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL async_quotient got %h want 0", quotient); end
    n_tests++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL async_remainder got %h want 0", remainder); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy got %b want 0", busy); end
    n_tests++; if (data_resultRDY !== 1'b0 || data_exception !== 1'b0) begin n_fail++; $display("FAIL async_flags got %b%b want 00", data_resultRDY, data_exception); end
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    stray = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY || busy) stray++;
    end
    n_tests++; if (stray !== 0) begin n_fail++; $display("FAIL abandoned_op got %0d active cycles want 0", stray); end
    run_op(32'd9, 32'd3, 0, lat, fb, fq, bs, q, r, e);
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL post_reset_latency got %0d want 33", lat); end
    n_tests++; if (q !== 32'd3 || r !== 32'd0) begin n_fail++; $display("FAIL post_reset_result got %h %h want 3 0", q, r); end
    run_op(32'd20, 32'd6, 0, lat, fb, fq, bs, q, r, e);
    n_tests++; if (fq !== 32'd3) begin n_fail++; $display("FAIL b2b_hold got %h want 3", fq); end
    n_tests++; if (fb !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b want 1", fb); end
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency got %0d want 33", lat); end
    n_tests++; if (q !== 32'd3 || r !== 32'd2 || e !== 1'b0) begin n_fail++; $display("FAIL b2b_result got %h %h %b want 3 2 0", q, r, e); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_div_zero();
    test_random();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
